pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/pc_gen_if.sv | 32 +++
 rtl/pc_redirect_sel.sv | 44 ++++
 rtl/pc_gen.sv | 118 +++++++++++
 tb/tb_pc_gen.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared CPU package for the PC generator: redirect priority codes and FSM states.
// Latency: n/a (constants, types and a helper only).
// Backpressure: n/a.
package pc_gen_pkg;

    // Redirect priority codes; a larger value means a higher priority.
    localparam logic [1:0] PRIO_BR   = 2'd0;
    localparam logic [1:0] PRIO_JR   = 2'd1;
    localparam logic [1:0] PRIO_ERET = 2'd2;
    localparam logic [1:0] PRIO_EXC  = 2'd3;

    // RUN: no redirect held. HOLD: a redirect is waiting for en.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_e;

    // A new request displaces a held one when it is at least as urgent.
    function automatic logic prio_wins(input logic [1:0] new_code,
                                       input logic [1:0] held_code);
        return new_code >= held_code;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Request/response bundle between the fetch controller and the PC generator.
// Latency: n/a (wires only).
// Backpressure: en is the stall input; pend reports a redirect parked during a stall.
// Ports: en, br_*, jr_*, exc_req, eret_req, epc in; pc, pc_plus4, pend, addr_err out.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             br_valid;
    logic [WIDTH-1:0] br_target;
    logic             jr_valid;
    logic [WIDTH-1:0] jr_target;
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             pend;
    logic             addr_err;

    // Requester side.
    modport master (
        output en, br_valid, br_target, jr_valid, jr_target, exc_req, eret_req, epc,
        input  pc, pc_plus4, pend, addr_err
    );

    // PC generator side.
    modport slave (
        input  en, br_valid, br_target, jr_valid, jr_target, exc_req, eret_req, epc,
        output pc, pc_plus4, pend, addr_err
    );
endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational priority selector: picks the most urgent of exc/eret/jr/br.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the selection is applied or held.
// Ports: i_* request valids/targets in; o_vld, o_tgt, o_code (priority code) out.
module pc_redirect_sel
    import pc_gen_pkg::*;
#(
    parameter int              WIDTH  = 32,
    parameter logic [WIDTH-1:0] EXC_PC = 32'h0000_4180
) (
    input  logic             i_exc_req,
    input  logic             i_eret_req,
    input  logic [WIDTH-1:0] i_epc,
    input  logic             i_jr_valid,
    input  logic [WIDTH-1:0] i_jr_target,
    input  logic             i_br_valid,
    input  logic [WIDTH-1:0] i_br_target,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_tgt,
    output logic [1:0]       o_code
);

    always_comb begin
        o_vld  = 1'b1;
        o_tgt  = '0;
        o_code = PRIO_BR;
        if (i_exc_req) begin
            o_tgt  = EXC_PC;
            o_code = PRIO_EXC;
        end else if (i_eret_req) begin
            o_tgt  = i_epc;
            o_code = PRIO_ERET;
        end else if (i_jr_valid) begin
            o_tgt  = i_jr_target;
            o_code = PRIO_JR;
        end else if (i_br_valid) begin
            o_tgt  = i_br_target;
            o_code = PRIO_BR;
        end else begin
            o_vld  = 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator with prioritised redirects that are held across stalls.
// Latency: redirect visible on pc one edge after it is sampled with en=1 (exc ignores en).
// Backpressure: en=0 stalls pc; the most urgent redirect is parked and pend is raised.
// Ports: clk, reset (async, active-high); bus = pc_gen_if.slave (requests in, pc/status out).
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_PC   = 32'h0000_4180
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.slave  bus
);

    pc_state_e        r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_hold_tgt;
    logic [1:0]       r_hold_code;

    pc_state_e        w_state_nxt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_hold_tgt_nxt;
    logic [1:0]       w_hold_code_nxt;
    logic [WIDTH-1:0] w_pc_plus4;

    logic             w_sel_vld;
    logic [WIDTH-1:0] w_sel_tgt;
    logic [1:0]       w_sel_code;
    logic             w_new_wins;

    // One selector serves both capture (RUN) and release/replace (HOLD).
    pc_redirect_sel #(
        .WIDTH  (WIDTH),
        .EXC_PC (EXC_PC)
    ) u_sel (
        .i_exc_req   (bus.exc_req),
        .i_eret_req  (bus.eret_req),
        .i_epc       (bus.epc),
        .i_jr_valid  (bus.jr_valid),
        .i_jr_target (bus.jr_target),
        .i_br_valid  (bus.br_valid),
        .i_br_target (bus.br_target),
        .o_vld       (w_sel_vld),
        .o_tgt       (w_sel_tgt),
        .o_code      (w_sel_code)
    );

    assign w_pc_plus4 = r_pc + WIDTH'(4);
    // Ties go to the new request so the most recent target of equal rank wins.
    assign w_new_wins = w_sel_vld && prio_wins(w_sel_code, r_hold_code);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_hold_tgt_nxt  = r_hold_tgt;
        w_hold_code_nxt = r_hold_code;
        if (bus.exc_req) begin
            // Exceptions cannot wait for a stall to clear; anything parked is stale.
            w_pc_nxt        = EXC_PC;
            w_state_nxt     = ST_RUN;
            w_hold_tgt_nxt  = '0;
            w_hold_code_nxt = PRIO_BR;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.en) begin
                        w_pc_nxt = w_sel_vld ? w_sel_tgt : w_pc_plus4;
                    end else if (w_sel_vld) begin
                        w_hold_tgt_nxt  = w_sel_tgt;
                        w_hold_code_nxt = w_sel_code;
                        w_state_nxt     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.en) begin
                        // The held redirect replaces the sequential step entirely.
                        w_pc_nxt        = w_new_wins ? w_sel_tgt : r_hold_tgt;
                        w_state_nxt     = ST_RUN;
                        w_hold_tgt_nxt  = '0;
                        w_hold_code_nxt = PRIO_BR;
                    end else if (w_new_wins) begin
                        w_hold_tgt_nxt  = w_sel_tgt;
                        w_hold_code_nxt = w_sel_code;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_hold_tgt  <= '0;
            r_hold_code <= PRIO_BR;
        end else begin
            r_pc        <= w_pc_nxt;
            r_hold_tgt  <= w_hold_tgt_nxt;
            r_hold_code <= w_hold_code_nxt;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus4 = w_pc_plus4;
    assign bus.pend     = (r_state == ST_HOLD);
    assign bus.addr_err = |r_pc[1:0];

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model: pc plus an optional parked redirect (rank and target).
    logic [31:0] m_pc;
    bit          m_held;
    int          m_hold_code;
    logic [31:0] m_hold_tgt;

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC),
        .EXC_PC   (EXC_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},       bus.pc,               m_pc);
        check({tag, ".pc_plus4"}, bus.pc_plus4,         m_pc + 32'd4);
        check({tag, ".pend"},     32'(bus.pend),        32'(m_held));
        check({tag, ".addr_err"}, 32'(bus.addr_err),    32'(m_pc[1:0] != 2'b00));
    endtask

    task automatic drive(input bit en, input bit brv, input logic [31:0] brt,
                         input bit jrv, input logic [31:0] jrt,
                         input bit exc, input bit eret, input logic [31:0] epc);
        bus.en        = en;
        bus.br_valid  = brv;
        bus.br_target = brt;
        bus.jr_valid  = jrv;
        bus.jr_target = jrt;
        bus.exc_req   = exc;
        bus.eret_req  = eret;
        bus.epc       = epc;
    endtask

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_held      = 0;
        m_hold_code = 0;
        m_hold_tgt  = '0;
    endtask

    // Behaviour of one rising edge, from the redirect rules directly.
    task automatic model_step();
        bit          v[4];
        logic [31:0] t[4];
        int          best;
        if (reset) begin
            model_reset();
            return;
        end
        v[0] = bus.br_valid; t[0] = bus.br_target;
        v[1] = bus.jr_valid; t[1] = bus.jr_target;
        v[2] = bus.eret_req; t[2] = bus.epc;
        v[3] = bus.exc_req;  t[3] = EXC_PC;
        best = -1;
        for (int i = 0; i < 4; i++) if (v[i]) best = i;
        if (bus.exc_req) begin
            m_pc   = EXC_PC;
            m_held = 0;
        end else if (bus.en) begin
            if (m_held && best < m_hold_code) m_pc = m_hold_tgt;
            else if (best >= 0)               m_pc = t[best];
            else                              m_pc = m_pc + 32'd4;
            m_held = 0;
        end else if (best >= 0 && (!m_held || best >= m_hold_code)) begin
            m_held      = 1;
            m_hold_code = best;
            m_hold_tgt  = t[best];
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(0, 0, '0, 0, '0, 0, 0, '0);
        model_reset();
        #3;
        check_model("reset");
        check("reset.pc_const", bus.pc, 32'h0000_3000);

        // Requests and en are ignored while reset is high.
        drive(1, 1, 32'h0000_5000, 1, 32'h0000_6000, 1, 1, 32'h0000_7000);
        tick("in_reset0");
        tick("in_reset1");
        check("in_reset.pc_const", bus.pc, 32'h0000_3000);
        #3 reset = 1'b0;
        drive(1, 0, '0, 0, '0, 0, 0, '0);

        // Sequential run after reset release.
        tick("seq0"); check("seq0.const", bus.pc, 32'h0000_3004);
        tick("seq1"); check("seq1.const", bus.pc, 32'h0000_3008);
        tick("seq2"); check("seq2.const", bus.pc, 32'h0000_300C);
        tick("seq3"); check("seq3.const", bus.pc, 32'h0000_3010);

        // jr beats br in the same cycle.
        drive(1, 1, 32'h0000_3100, 1, 32'h0000_3200, 0, 0, '0);
        tick("jr_over_br"); check("jr_over_br.const", bus.pc, 32'h0000_3200);

        // Held br replaced by a later jr, released on en.
        drive(0, 1, 32'h0000_3100, 0, '0, 0, 0, '0);
        tick("hold_br"); check("hold_br.pend", 32'(bus.pend), 32'd1);
        drive(0, 0, '0, 1, 32'h0000_3200, 0, 0, '0);
        tick("hold_jr"); check("hold_jr.pend", 32'(bus.pend), 32'd1);
        drive(1, 0, '0, 0, '0, 0, 0, '0);
        tick("release"); check("release.pc", bus.pc, 32'h0000_3200);
        check("release.pend", 32'(bus.pend), 32'd0);

        // Exception overrides stall and discards the held redirect; then eret.
        drive(0, 1, 32'h0000_3100, 0, '0, 0, 0, '0);
        tick("hold_br2");
        drive(0, 0, '0, 0, '0, 1, 0, '0);
        tick("exc_stall"); check("exc_stall.pc", bus.pc, 32'h0000_4180);
        check("exc_stall.pend", 32'(bus.pend), 32'd0);
        drive(1, 0, '0, 0, '0, 0, 1, 32'h0000_3104);
        tick("eret"); check("eret.pc", bus.pc, 32'h0000_3104);

        // Wrap of pc_plus4 and misaligned targets.
        drive(1, 0, '0, 1, 32'hFFFF_FFFC, 0, 0, '0);
        tick("jr_top"); check("jr_top.plus4", bus.pc_plus4, 32'h0000_0000);
        drive(1, 0, '0, 0, '0, 0, 0, '0);
        tick("wrap"); check("wrap.pc", bus.pc, 32'h0000_0000);
        drive(1, 0, '0, 1, 32'h0000_3002, 0, 0, '0);
        tick("misalign"); check("misalign.addr_err", 32'(bus.addr_err), 32'd1);

        // Asynchronous reset in HOLD takes effect before the next edge.
        drive(0, 1, 32'h0000_3100, 0, '0, 0, 0, '0);
        tick("hold_br3");
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_rst.pc", bus.pc, 32'h0000_3000);
        check("async_rst.pend", 32'(bus.pend), 32'd0);
        check_model("async_rst");
        tick("rst_hold");
        #3 reset = 1'b0;
        drive(1, 0, '0, 0, '0, 0, 0, '0);
        tick("post_rst"); check("post_rst.pc", bus.pc, 32'h0000_3004);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] bt, jt, et;
            bt = $urandom; jt = $urandom; et = $urandom;
            if ($urandom_range(0, 15) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 15) != 0) jt[1:0] = 2'b00;
            if ($urandom_range(0, 15) != 0) et[1:0] = 2'b00;
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 9) < 5,
                  $urandom_range(0, 3) == 0, bt,
                  $urandom_range(0, 4) == 0, jt,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 7) == 0, et);
            tick("rand");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
